blink_sched: RTL and testbench



---
 rtl/blink_sched.sv | 142 ++++++++++++++
 tb/tb_blink_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_sched.sv
// Multi-channel LED blink scheduler: one shared tick prescaler, one ON/OFF sequencer per channel.
// Define BLINK_RESYNC_EN to make every accepted enable command restart the prescaler.
module blink_sched_ch #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          wr,
  input  logic          en,
  input  logic [PW-1:0] on,
  input  logic [PW-1:0] off,
  output logic          led,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ON, OFF} st_t;

  st_t           st, nst;
  logic [PW-1:0] rem, nrem, on_p, off_p, non_p, noff_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      rem   <= '0;
      on_p  <= '0;
      off_p <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      st    <= nst;
      rem   <= nrem;
      on_p  <= non_p;
      off_p <= noff_p;
      led   <= (nst == ON);
      busy  <= (nst != IDLE);
    end
  end

  // A command and a tick never share an edge, so the command branch wins outright.
  always_comb begin
    nst    = st;
    nrem   = rem;
    non_p  = on_p;
    noff_p = off_p;
    if (wr) begin
      if (en) begin
        non_p  = on;
        noff_p = off;
        if (on != '0) begin
          nst  = ON;
          nrem = on;
        end else if (off != '0) begin
          nst  = OFF;
          nrem = off;
        end else begin
          nst  = IDLE;
          nrem = '0;
        end
      end else begin
        nst  = IDLE;
        nrem = '0;
      end
    end else if (tick && st != IDLE) begin
      if (rem > PW'(1)) begin
        nrem = rem - 1'b1;
      end else if (st == ON) begin
        if (off_p != '0) begin
          nst  = OFF;
          nrem = off_p;
        end else begin
          nrem = on_p;
        end
      end else begin
        if (on_p != '0) begin
          nst  = ON;
          nrem = on_p;
        end else begin
          nrem = off_p;
        end
      end
    end
  end
endmodule

module blink_sched #(
  parameter  int CBITS = 17,
  parameter  int NCH   = 4,
  parameter  int PW    = 8,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic           cfg_en,
  input  logic [PW-1:0]  cfg_on,
  input  logic [PW-1:0]  cfg_off,
  output logic [NCH-1:0] led,
  output logic           flg,
  output logic [NCH-1:0] busy
);
  logic [CBITS-1:0] cnt;
  logic             tick, acc, clr;
  logic [NCH-1:0]   wr;

  assign tick      = &cnt;
  assign cfg_ready = !tick;
  assign acc       = cfg_valid && !tick;

`ifdef BLINK_RESYNC_EN
  assign clr = acc && cfg_en;
`else
  assign clr = 1'b0;
`endif

  // flg follows the natural wrap only; a forced clear never raises it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      flg <= 1'b0;
    end else begin
      flg <= tick;
      cnt <= clr ? '0 : cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr[i] = acc && (cfg_ch == CHW'(i));
    blink_sched_ch #(.PW(PW)) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .wr   (wr[i]),
      .en   (cfg_en),
      .on   (cfg_on),
      .off  (cfg_off),
      .led  (led[i]),
      .busy (busy[i])
    );
  end
endmodule

// File: tb/tb_blink_sched.sv
// Self-checking bench for blink_sched: expected flg/busy/led queued per driven cycle, popped after the edge.
module tb_blink_sched;
  localparam int CBITS = 3;
  localparam int NCH   = 4;
  localparam int PW    = 4;
  localparam int TPER  = 1 << CBITS;
`ifdef BLINK_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           cfg_valid = 1'b0, cfg_en = 1'b0, cfg_ready, flg;
  logic [1:0]     cfg_ch = '0;
  logic [PW-1:0]  cfg_on = '0, cfg_off = '0;
  logic [NCH-1:0] led, busy;

  int ncmp = 0, nerr = 0;
  int pc;
  int mon[NCH], moff[NCH], mtk[NCH];
  bit mact[NCH];
  logic [2*NCH:0] q[$];

  blink_sched #(.CBITS(CBITS), .NCH(NCH), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_on(cfg_on), .cfg_off(cfg_off),
    .led(led), .flg(flg), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Phase from ticks elapsed since start: ON for the first mon ticks of each on+off cycle.
  function automatic logic [2*NCH:0] expv(input bit fl);
    logic [NCH-1:0] l, b;
    l = '0;
    b = '0;
    for (int i = 0; i < NCH; i++) begin
      if (mact[i]) begin
        b[i] = 1'b1;
        if (moff[i] == 0) l[i] = (mon[i] != 0);
        else              l[i] = (mtk[i] % (mon[i] + moff[i])) < mon[i];
      end
    end
    return {fl, b, l};
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < NCH; i++) begin
      mact[i] = 0; mon[i] = 0; moff[i] = 0; mtk[i] = 0;
    end
    pc = 0;
  endfunction

  task automatic step(input bit v, input int ch, input bit en, input int on, input int off,
                      output bit acc);
    bit efl;
    cfg_valid = v;
    cfg_ch    = ch[1:0];
    cfg_en    = en;
    cfg_on    = on[PW-1:0];
    cfg_off   = off[PW-1:0];
    acc = v && (pc != TPER - 1);
    efl = (pc == TPER - 1);
    if (acc) begin
      if (ch < NCH) begin
        if (en) begin
          mon[ch] = on; moff[ch] = off; mtk[ch] = 0;
          mact[ch] = (on != 0) || (off != 0);
        end else begin
          mact[ch] = 0;
        end
      end
      pc = (RESYNC && en) ? 0 : (pc + 1) % TPER;
    end else begin
      if (efl)
        for (int i = 0; i < NCH; i++) if (mact[i]) mtk[i]++;
      pc = (pc + 1) % TPER;
    end
    q.push_back(expv(efl));
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    #3;
    ncmp++;
    if ({flg, busy, led} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs got=%b expected=%b", {flg, busy, led}, {(2*NCH+1){1'b0}});
    end
    ncmp++;
    if (cfg_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_ready got=%b expected=1", cfg_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    logic [2*NCH:0] e;
    bit acc;
    for (int n = 0; n < 3 * TPER; n++) begin
      ncmp++;
      if (cfg_ready !== (pc != TPER - 1)) begin
        nerr++;
        $display("FAIL idle_ready pc=%0d got=%b expected=%b", pc, cfg_ready, pc != TPER - 1);
      end
      step(0, 0, 0, 0, 0, acc);
      e = q.pop_front();
      ncmp++;
      if ({flg, busy, led} !== e) begin
        nerr++;
        $display("FAIL idle t=%0t got=%b expected=%b", $time, {flg, busy, led}, e);
      end
    end
  endtask

  task automatic test_blink();
    logic [2*NCH:0] e;
    bit acc;
    while (pc != 0) begin
      step(0, 0, 0, 0, 0, acc);
      e = q.pop_front();
      ncmp++;
      if ({flg, busy, led} !== e) begin
        nerr++;
        $display("FAIL blink_align got=%b expected=%b", {flg, busy, led}, e);
      end
    end
    step(1, 0, 1, 2, 1, acc);
    for (int n = 0; n < 8 * TPER; n++) begin
      if (n > 0) step(0, 0, 0, 0, 0, acc);
      e = q.pop_front();
      ncmp++;
      if ({flg, busy, led} !== e) begin
        nerr++;
        $display("FAIL blink n=%0d got=%b expected=%b", n, {flg, busy, led}, e);
      end
    end
  endtask

  task automatic test_steady();
    logic [2*NCH:0] e;
    bit acc;
    step(1, 1, 1, 3, 0, acc);
    for (int n = 0; n < 5 * TPER; n++) begin
      if (n > 0) step(0, 0, 0, 0, 0, acc);
      e = q.pop_front();
      ncmp++;
      if ({flg, busy, led} !== e) begin
        nerr++;
        $display("FAIL steady n=%0d got=%b expected=%b", n, {flg, busy, led}, e);
      end
    end
    if (pc == TPER - 1) step(0, 0, 0, 0, 0, acc);
    while (q.size() > 0) e = q.pop_front();
    step(1, 1, 1, 0, 0, acc);
    e = q.pop_front();
    ncmp++;
    if ({busy[1], led[1]} !== 2'b00 || {flg, busy, led} !== e) begin
      nerr++;
      $display("FAIL steady_off got=%b expected=%b", {flg, busy, led}, e);
    end
  endtask

  task automatic test_ready_hold();
    logic [2*NCH:0] e;
    bit acc;
    while (pc != TPER - 1) begin
      step(0, 0, 0, 0, 0, acc);
      e = q.pop_front();
      ncmp++;
      if ({flg, busy, led} !== e) begin
        nerr++;
        $display("FAIL hold_align got=%b expected=%b", {flg, busy, led}, e);
      end
    end
    cfg_valid = 1'b1;
    #1;
    ncmp++;
    if (cfg_ready !== 1'b0) begin
      nerr++;
      $display("FAIL hold_ready_tick got=%b expected=0", cfg_ready);
    end
    step(1, 3, 1, 1, 1, acc);
    e = q.pop_front();
    ncmp++;
    if ({flg, busy, led} !== e) begin
      nerr++;
      $display("FAIL hold_stall got=%b expected=%b", {flg, busy, led}, e);
    end
    cfg_valid = 1'b1;
    #1;
    ncmp++;
    if (cfg_ready !== 1'b1) begin
      nerr++;
      $display("FAIL hold_ready_next got=%b expected=1", cfg_ready);
    end
    step(1, 3, 1, 1, 1, acc);
    for (int n = 0; n < 4 * TPER; n++) begin
      if (n > 0) step(0, 0, 0, 0, 0, acc);
      e = q.pop_front();
      ncmp++;
      if ({flg, busy, led} !== e || (n == 0 && {busy[3], led[3]} !== 2'b11)) begin
        nerr++;
        $display("FAIL hold_run n=%0d got=%b expected=%b", n, {flg, busy, led}, e);
      end
    end
  endtask

  task automatic test_stop_restart();
    logic [2*NCH:0] e;
    bit acc;
    for (int k = 0; k < 3; k++) begin
      if (pc == TPER - 1) begin
        step(0, 0, 0, 0, 0, acc);
        e = q.pop_front();
      end
      case (k)
        0: step(1, 2, 1, 2, 2, acc);
        1: step(1, 2, 0, 0, 0, acc);
        default: step(1, 2, 1, 2, 2, acc);
      endcase
      for (int n = 0; n < 3 * TPER; n++) begin
        if (n > 0) step(0, 0, 0, 0, 0, acc);
        e = q.pop_front();
        ncmp++;
        if ({flg, busy, led} !== e) begin
          nerr++;
          $display("FAIL stop_restart k=%0d n=%0d got=%b expected=%b", k, n, {flg, busy, led}, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2*NCH:0] e;
    bit acc;
    while (pc != 0) begin
      step(0, 0, 0, 0, 0, acc);
      e = q.pop_front();
    end
    step(1, 0, 1, 3, 2, acc);
    e = q.pop_front();
    step(1, 2, 1, 3, 1, acc);
    e = q.pop_front();
    do begin
      step(0, 0, 0, 0, 0, acc);
      e = q.pop_front();
      ncmp++;
      if ({flg, busy, led} !== e) begin
        nerr++;
        $display("FAIL rstmid_pre got=%b expected=%b", {flg, busy, led}, e);
      end
    end while (pc != 0);
    #2;
    rst_n = 1'b0;
    #1;
    ncmp++;
    if ({flg, busy, led} !== '0) begin
      nerr++;
      $display("FAIL rstmid_async got=%b expected=%b", {flg, busy, led}, {(2*NCH+1){1'b0}});
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3 * TPER; n++) begin
      step(0, 0, 0, 0, 0, acc);
      e = q.pop_front();
      ncmp++;
      if ({flg, busy, led} !== e) begin
        nerr++;
        $display("FAIL rstmid_post n=%0d got=%b expected=%b", n, {flg, busy, led}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_blink();
    test_steady();
    test_ready_hold();
    test_stop_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
